// File: rtl/ss2_uart_rx.sv
// UART receiver: 2-flop synchronized line, centre-sampled frames, one-byte holding register with overrun flag.
// Optional build macro SS2_UART_RX_MAJORITY_EN makes every bit decision a 2-of-3 vote over the last three rxd_s values.
module ss2_uart_rx #(
  parameter int pBIT_RATE  = 32,
  parameter int pDATA_BITS = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  rxd,
  output logic [pDATA_BITS-1:0] data,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  frame_error,
  output logic                  overrun,
  input  logic                  overrun_clear,
  output logic                  busy
);

  localparam int CW = $clog2(pBIT_RATE);
  localparam int IW = $clog2(pDATA_BITS);
  localparam logic [CW-1:0] HALF_LAST = CW'(pBIT_RATE / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(pBIT_RATE - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(pDATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_BREAK
  } state_t;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic [pDATA_BITS-1:0]   shift_q, shift_d;
  logic [1:0]              sync_q;
  logic [1:0]              flush_q;
  logic                    armed_q;
  logic                    rxd_s;
  logic                    sample;
  logic                    deliver;
  logic                    bad_stop;

  // Synchronizer flops reset to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      sync_q <= 2'b11;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      sync_q <= {sync_q[0], rxd};
    end
  end

  assign rxd_s = sync_q[1];

`ifdef SS2_UART_RX_MAJORITY_EN
  logic [1:0] hist_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      hist_q <= 2'b11;
    end else begin
      hist_q <= {hist_q[0], rxd_s};
    end
  end

  assign sample = (rxd_s & hist_q[0]) | (rxd_s & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign sample = rxd_s;
`endif

  // After reset the forced-high synchronizer must flush and the real line must be seen high
  // before a low level counts as a start bit; a frame cut by reset is thereby ignored.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      flush_q <= 2'b00;
      armed_q <= 1'b0;
    end else begin
      flush_q <= {flush_q[0], 1'b1};
      if (flush_q[1] && rxd_s) begin
        armed_q <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    state_d  = state_q;
    cnt_d    = cnt_q + 1'b1;
    idx_d    = idx_q;
    shift_d  = shift_q;
    deliver  = 1'b0;
    bad_stop = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (armed_q && !rxd_s) begin
          state_d = S_START;
        end
      end

      S_START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = sample ? S_IDLE : S_DATA;
        end
      end

      S_DATA: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d   = '0;
          shift_d = {sample, shift_q[pDATA_BITS-1:1]};
          if (idx_q == IDX_LAST) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end

      S_STOP: begin
        if (cnt_q == FULL_LAST) begin
          cnt_d = '0;
          if (sample) begin
            deliver = 1'b1;
            state_d = S_IDLE;
          end else begin
            bad_stop = 1'b1;
            state_d  = S_BREAK;
          end
        end
      end

      S_BREAK: begin
        cnt_d = '0;
        if (rxd_s) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = S_IDLE;
      end
    endcase
  end

  assign busy = (state_q != S_IDLE);

  // Holding register: a delivery coinciding with consumption reloads; otherwise a full register drops it.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data        <= '0;
      data_valid  <= 1'b0;
      frame_error <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      frame_error <= bad_stop;

      if (deliver && (!data_valid || data_ready)) begin
        data       <= shift_q;
        data_valid <= 1'b1;
      end else if (data_valid && data_ready) begin
        data_valid <= 1'b0;
      end

      if (deliver && data_valid && !data_ready) begin
        overrun <= 1'b1;
      end else if (overrun_clear) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_ss2_uart_rx.sv
// Self-checking bench for ss2_uart_rx: line waveforms are built tick by tick and decoded by a
// centre-sampling reference model; a negedge monitor logs every accepted byte and flag.
module tb_ss2_uart_rx;

  localparam int BR = 32;
  localparam int DB = 8;
  // Line tick whose value the stop-bit decision sees, plus two synchronizer stages.
  localparam int DELIVER_TICK = BR / 2 + 9 * BR + 2;

  logic          clk = 1'b0;
  logic          resetn;
  logic          rxd;
  logic [DB-1:0] data;
  logic          data_valid;
  logic          data_ready;
  logic          frame_error;
  logic          overrun;
  logic          overrun_clear;
  logic          busy;

  int total = 0;
  int bad   = 0;

  int            valid_cycles = 0;
  int            fe_pulses    = 0;
  int            busy_cycles  = 0;
  int            got_n        = 0;
  logic [DB-1:0] got_mem [0:255];

  logic          wave [0:1023];
  int            wave_len;

  always #5 clk = ~clk;

  ss2_uart_rx #(
    .pBIT_RATE (BR),
    .pDATA_BITS(DB)
  ) dut (
    .clk          (clk),
    .resetn       (resetn),
    .rxd          (rxd),
    .data         (data),
    .data_valid   (data_valid),
    .data_ready   (data_ready),
    .frame_error  (frame_error),
    .overrun      (overrun),
    .overrun_clear(overrun_clear),
    .busy         (busy)
  );

  always begin
    @(negedge clk);
    #1;
    if (resetn) begin
      if (data_valid)  valid_cycles++;
      if (frame_error) fe_pulses++;
      if (busy)        busy_cycles++;
      if (data_valid && data_ready && got_n < 256) begin
        got_mem[got_n] = data;
        got_n++;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // One frame as a per-clock line waveform; tail extends the stop level, glitch pulls each data centre low.
  task automatic build_frame(input logic [7:0] b, input logic stop, input bit glitch, input int tail);
    wave_len = 10 * BR + tail;
    for (int t = 0; t < wave_len; t++) begin
      int k;
      k = t / BR;
      if (k == 0)      wave[t] = 1'b0;
      else if (k <= 8) wave[t] = b[k-1];
      else             wave[t] = stop;
    end
    if (glitch) begin
      for (int i = 0; i < 8; i++) wave[BR / 2 + (i + 1) * BR] = 1'b0;
    end
  endtask

  function automatic logic decide_at(input int s);
`ifdef SS2_UART_RX_MAJORITY_EN
    return (wave[s] & wave[s-1]) | (wave[s] & wave[s-2]) | (wave[s-1] & wave[s-2]);
`else
    return wave[s];
`endif
  endfunction

  function automatic logic [7:0] model_byte();
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = decide_at(BR / 2 + (i + 1) * BR);
    return r;
  endfunction

  function automatic logic model_stop_ok();
    return decide_at(BR / 2 + 9 * BR);
  endfunction

  task automatic drive_wave(input int ready_tick);
    for (int t = 0; t < wave_len; t++) begin
      rxd = wave[t];
      if (ready_tick >= 0) data_ready = (t == ready_tick);
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    resetn = 1'b0; rxd = 1'b1; data_ready = 1'b0; overrun_clear = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (data !== 8'h00)       begin bad++; $display("FAIL reset_data got=%h exp=00", data); end
    total++; if (data_valid !== 1'b0)  begin bad++; $display("FAIL reset_valid got=%b exp=0", data_valid); end
    total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL reset_fe got=%b exp=0", frame_error); end
    total++; if (overrun !== 1'b0)     begin bad++; $display("FAIL reset_overrun got=%b exp=0", overrun); end
    total++; if (busy !== 1'b0)        begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    resetn = 1'b1;
    idle(10);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL post_reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_basic();
    int v0, f0, g0;
    logic [7:0] exp_b;
    data_ready = 1'b1;
    v0 = valid_cycles; f0 = fe_pulses; g0 = got_n;
    build_frame(8'hA5, 1'b1, 1'b0, 0);
    exp_b = model_byte();
    drive_wave(-1);
    idle(BR);
    total++; if (got_n - g0 !== 1) begin bad++; $display("FAIL basic_count got=%0d exp=1", got_n - g0); end
    else begin
      total++; if (got_mem[g0] !== exp_b) begin bad++; $display("FAIL basic_data got=%h exp=%h", got_mem[g0], exp_b); end
    end
    total++; if (valid_cycles - v0 !== 1) begin bad++; $display("FAIL basic_valid_len got=%0d exp=1", valid_cycles - v0); end
    total++; if (fe_pulses - f0 !== 0) begin bad++; $display("FAIL basic_fe got=%0d exp=0", fe_pulses - f0); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL basic_overrun got=%b exp=0", overrun); end
  endtask

  task automatic test_start_glitch();
    int v0, f0, b0;
    v0 = valid_cycles; f0 = fe_pulses; b0 = busy_cycles;
    rxd = 1'b0;
    repeat (8) @(negedge clk);
    idle(2 * BR);
    total++; if (busy_cycles - b0 <= 0) begin bad++; $display("FAIL glitch_busy_seen got=%0d exp=>0", busy_cycles - b0); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
    total++; if (valid_cycles - v0 !== 0) begin bad++; $display("FAIL glitch_valid got=%0d exp=0", valid_cycles - v0); end
    total++; if (fe_pulses - f0 !== 0) begin bad++; $display("FAIL glitch_fe got=%0d exp=0", fe_pulses - f0); end
  endtask

  task automatic test_frame_error();
    int v0, f0, exp_fe;
    v0 = valid_cycles; f0 = fe_pulses;
    build_frame(8'h3C, 1'b0, 1'b0, 100);
    exp_fe = model_stop_ok() ? 0 : 1;
    drive_wave(-1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL fe_busy_low_line got=%b exp=1", busy); end
    idle(8);
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL fe_busy_after got=%b exp=0", busy); end
    total++; if (fe_pulses - f0 !== exp_fe) begin bad++; $display("FAIL fe_pulses got=%0d exp=%0d", fe_pulses - f0, exp_fe); end
    total++; if (valid_cycles - v0 !== 0) begin bad++; $display("FAIL fe_valid got=%0d exp=0", valid_cycles - v0); end
  endtask

  task automatic test_overrun();
    int g0;
    logic [7:0] first_b;
    g0 = got_n;
    data_ready = 1'b0;
    build_frame(8'h11, 1'b1, 1'b0, 0);
    first_b = model_byte();
    drive_wave(-1);
    idle(BR);
    build_frame(8'h22, 1'b1, 1'b0, 0);
    drive_wave(-1);
    idle(BR);
    total++; if (data !== first_b) begin bad++; $display("FAIL ovr_data_kept got=%h exp=%h", data, first_b); end
    total++; if (data_valid !== 1'b1) begin bad++; $display("FAIL ovr_valid got=%b exp=1", data_valid); end
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL ovr_set got=%b exp=1", overrun); end
    overrun_clear = 1'b1;
    @(negedge clk);
    overrun_clear = 1'b0;
    @(negedge clk);
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL ovr_clear got=%b exp=0", overrun); end
    data_ready = 1'b1;
    @(negedge clk);
    data_ready = 1'b0;
    @(negedge clk);
    total++; if (data_valid !== 1'b0) begin bad++; $display("FAIL ovr_consumed got=%b exp=0", data_valid); end
    total++; if (got_n - g0 !== 1) begin bad++; $display("FAIL ovr_accept_count got=%0d exp=1", got_n - g0); end
    else begin
      total++; if (got_mem[g0] !== first_b) begin bad++; $display("FAIL ovr_accept_data got=%h exp=%h", got_mem[g0], first_b); end
    end
  endtask

  task automatic test_back_to_back();
    int g0;
    logic [7:0] a_b, b_b;
    logic [7:0] ra, rb;
    ra = 8'($urandom_range(0, 255));
    rb = 8'($urandom_range(0, 255));
    g0 = got_n;
    data_ready = 1'b0;
    build_frame(ra, 1'b1, 1'b0, 0);
    a_b = model_byte();
    drive_wave(-1);
    build_frame(rb, 1'b1, 1'b0, 0);
    b_b = model_byte();
    drive_wave(DELIVER_TICK);
    data_ready = 1'b0;
    idle(2);
    total++; if (got_n - g0 !== 1) begin bad++; $display("FAIL b2b_accept_count got=%0d exp=1", got_n - g0); end
    else begin
      total++; if (got_mem[g0] !== a_b) begin bad++; $display("FAIL b2b_first got=%h exp=%h", got_mem[g0], a_b); end
    end
    total++; if (data !== b_b || data_valid !== 1'b1) begin bad++; $display("FAIL b2b_reload got=%h/%b exp=%h/1", data, data_valid, b_b); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL b2b_overrun got=%b exp=0", overrun); end
    data_ready = 1'b1;
    idle(2);
  endtask

  task automatic test_reset_midframe();
    int g0, v0;
    logic [7:0] exp_b;
    data_ready = 1'b1;
    rxd = 1'b0;
    repeat (4 * BR) @(negedge clk);
    rxd = 1'b1;
    repeat (BR / 2) @(negedge clk);
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (busy !== 1'b0 || data_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_outputs busy=%b valid=%b exp=0/0", busy, data_valid); end
    resetn = 1'b1;
    g0 = got_n; v0 = valid_cycles;
    idle(BR / 2 + 6 * BR);
    total++; if (valid_cycles - v0 !== 0) begin bad++; $display("FAIL rst_mid_stale got=%0d exp=0", valid_cycles - v0); end
    build_frame(8'h5A, 1'b1, 1'b0, 0);
    exp_b = model_byte();
    drive_wave(-1);
    idle(BR);
    total++; if (got_n - g0 !== 1) begin bad++; $display("FAIL rst_mid_count got=%0d exp=1", got_n - g0); end
    else begin
      total++; if (got_mem[g0] !== exp_b) begin bad++; $display("FAIL rst_mid_data got=%h exp=%h", got_mem[g0], exp_b); end
    end
  endtask

  task automatic test_glitch_data();
    int g0;
    logic [7:0] exp_b;
    g0 = got_n;
    data_ready = 1'b1;
    build_frame(8'hFF, 1'b1, 1'b1, 0);
    exp_b = model_byte();
    drive_wave(-1);
    idle(BR);
    total++; if (got_n - g0 !== 1) begin bad++; $display("FAIL glitch_data_count got=%0d exp=1", got_n - g0); end
    else begin
      total++; if (got_mem[g0] !== exp_b) begin bad++; $display("FAIL glitch_data got=%h exp=%h", got_mem[g0], exp_b); end
`ifdef SS2_UART_RX_MAJORITY_EN
      total++; if (got_mem[g0] !== 8'hFF) begin bad++; $display("FAIL glitch_vote got=%h exp=ff", got_mem[g0]); end
`else
      total++; if (got_mem[g0] !== 8'h00) begin bad++; $display("FAIL glitch_single got=%h exp=00", got_mem[g0]); end
`endif
    end
  endtask

  task automatic test_random();
    data_ready = 1'b1;
    for (int n = 0; n < 10; n++) begin
      int g0, f0;
      logic [7:0] b, exp_b;
      b = 8'($urandom_range(0, 255));
      g0 = got_n; f0 = fe_pulses;
      build_frame(b, 1'b1, 1'b0, 0);
      exp_b = model_byte();
      drive_wave(-1);
      total++; if (got_n - g0 !== 1) begin bad++; $display("FAIL rand%0d_count got=%0d exp=1", n, got_n - g0); end
      else begin
        total++; if (got_mem[g0] !== exp_b) begin bad++; $display("FAIL rand%0d_data got=%h exp=%h", n, got_mem[g0], exp_b); end
      end
      total++; if (fe_pulses - f0 !== 0) begin bad++; $display("FAIL rand%0d_fe got=%0d exp=0", n, fe_pulses - f0); end
      idle($urandom_range(0, 40));
    end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL rand_overrun got=%b exp=0", overrun); end
  endtask

  initial begin
    resetn = 1'b0; rxd = 1'b1; data_ready = 1'b0; overrun_clear = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_start_glitch();
    test_frame_error();
    test_overrun();
    test_back_to_back();
    test_reset_midframe();
    test_glitch_data();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ss2_uart_rx.md
SS2_UART_RX -- requirements
Module: ss2_uart_rx

Interface
REQ-001 SHALL have parameter pBIT_RATE, default 32, clocks per UART bit (even, >=8).
REQ-002 SHALL have parameter pDATA_BITS, default 8, data bits per frame (5..8).
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port rxd  input  1  asynchronous UART line; idle high.
REQ-006 SHALL have port data  output  pDATA_BITS  received byte in the holding register.
REQ-007 SHALL have port data_valid  output  1  holding register contains an unconsumed byte.
REQ-008 SHALL have port data_ready  input  1  consumer accepts data when data_valid & data_ready.
REQ-009 SHALL have port frame_error  output  1  one-cycle pulse on a bad stop bit.
REQ-010 SHALL have port overrun  output  1  sticky flag; a completed byte was dropped.
REQ-011 SHALL have port overrun_clear  input  1  synchronous clear of overrun.
REQ-012 SHALL have port busy  output  1  high in any state other than IDLE.

Function
REQ-013 SHALL pass rxd through a 2-flop synchronizer (rxd_s); no other logic reads rxd.
REQ-014 SHALL implement states IDLE, START, DATA, STOP, BREAK with a bit-period counter and a bit index.
REQ-015 IDLE: rxd_s==0 -> START, counter=0.
REQ-016 START: at counter==pBIT_RATE/2-1, sample; sample 1 -> IDLE (glitch, no output, no error); sample 0 -> DATA, counter=0, index=0.
REQ-017 DATA: sample at counter==pBIT_RATE-1, shift in LSB first, counter=0; after pDATA_BITS samples -> STOP.
REQ-018 STOP: sample at counter==pBIT_RATE-1; 1 -> deliver byte, IDLE; 0 -> frame_error pulse, byte discarded, BREAK.
REQ-019 BREAK: stay until rxd_s==1, then IDLE; no frame_error repeat.
REQ-020 Delivery: data and data_valid SHALL update on the cycle after the good stop sample.
REQ-021 data_valid SHALL stay high, data stable, until a cycle with data_ready=1; data_valid falls the next cycle.
REQ-022 Delivery while data_valid=1 and data_ready=0: new byte dropped, old byte retained, overrun set.
REQ-023 Delivery in the same cycle as consumption: new byte loaded, data_valid stays 1, no overrun.
REQ-024 overrun_clear and a simultaneous overrun event: set wins.
REQ-025 data_ready while data_valid=0 SHALL have no effect.

Reset
REQ-026 resetn low SHALL asynchronously force state IDLE, counters 0, synchronizer flops 1, data 0, data_valid 0, frame_error 0, overrun 0, busy 0.
REQ-027 Reset mid-frame SHALL abandon the frame; after release a frame SHALL be recognised only from a new falling edge of rxd_s.

Configuration
REQ-028 Macro SS2_UART_RX_MAJORITY_EN defined: every sample (start, data, stop) SHALL be the 2-of-3 majority of rxd_s at the sampling cycle and the two cycles preceding it.
REQ-029 Macro undefined: every sample SHALL be the single rxd_s value at the sampling cycle; timing otherwise identical.

Verification
REQ-030 pBIT_RATE=32, frame 0xA5 8N1, data_ready=1 -> data=0xA5, data_valid high exactly one cycle, no frame_error/overrun.
REQ-031 rxd low for 8 clocks then high -> busy high then low, no data_valid, no frame_error.
REQ-032 Frame 0x3C with stop bit 0, line held low 100 clocks -> one frame_error pulse, no data_valid, busy until rxd_s high.
REQ-033 Frames 0x11 then 0x22, data_ready=0 -> data=0x11 retained, overrun=1; overrun_clear pulse -> overrun=0.
REQ-034 resetn low during bit 3 of a frame, released mid-frame -> no data_valid until a complete new frame 0x5A is received correctly.
REQ-035 Frame 0xFF with a one-clock low glitch on each data-bit sample point -> data=0xFF with SS2_UART_RX_MAJORITY_EN, data=0x00 without.
